// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
// Execute-stage sequencer for the 8-bit ALU_J datapath of the Jac1-8 core.
// Takes one ALU command per valid/ready handshake and reads both operands from
// an internal register file. It drives the registered ALU_J inputs, captures
// the result and status, and writes the result back.
//
// Optional feature macro: ALU_CMP_EN
//   When defined, opcode 0x0A (CMP) is legal. It runs as SUB on the ALU,
//   updates the flags, and skips the register write. When not defined, 0x0A
//   is handled like any other illegal opcode.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready command handshake
//   cmd_opcode      ALU opcode (5b)
//   cmd_dst         destination register index
//   cmd_src1        operand-1 register index
//   cmd_src2        operand-2 register index
//   cmd_param       shift amount / immediate
//   ld_en/addr/data external register-file write port (WB has priority)
//   alu_opcode      registered opcode output to ALU_J
//   alu_op1         registered operand-1 output to ALU_J
//   alu_op2         registered operand-2 output to ALU_J
//   alu_param       registered param output to ALU_J
//   alu_result      combinational result returned from ALU_J
//   alu_status      combinational status returned from ALU_J
//   flags           last captured status
//                   {smaller, greater, equal, zero, underflow, carry}
//   done            one-cycle pulse when a command retires
//   err             one-cycle pulse with done for an illegal opcode
//   dbg_addr/data   combinational register-file read port
//
// FSM states
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for cmd_valid
//   READ   | operands fetched, ALU inputs registered
//   EXEC   | ALU evaluates; result and status captured at the edge
//   WB     | result written back, done (and err) pulse
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 6,
  parameter int NumRegs       = 8,
  parameter int RegAddrBits   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [NumOpCodeBits-1:0] cmd_opcode,
  input  logic [RegAddrBits-1:0]   cmd_dst,
  input  logic [RegAddrBits-1:0]   cmd_src1,
  input  logic [RegAddrBits-1:0]   cmd_src2,
  input  logic [ParamBits-1:0]     cmd_param,
  input  logic                     ld_en,
  input  logic [RegAddrBits-1:0]   ld_addr,
  input  logic [DataWidth-1:0]     ld_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_op1,
  output logic [DataWidth-1:0]     alu_op2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] flags,
  output logic                     done,
  output logic                     err,
  input  logic [RegAddrBits-1:0]   dbg_addr,
  output logic [DataWidth-1:0]     dbg_data
);

  localparam logic [NumOpCodeBits-1:0] OpLastLegal = NumOpCodeBits'(9);
  localparam logic [NumOpCodeBits-1:0] OpCmp       = NumOpCodeBits'(10);
  localparam logic [NumOpCodeBits-1:0] OpSub       = NumOpCodeBits'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t                     r_state;
  logic [DataWidth-1:0]       r_regs [NumRegs];
  logic [NumOpCodeBits-1:0]   r_opcode;
  logic [RegAddrBits-1:0]     r_dst;
  logic [RegAddrBits-1:0]     r_src1;
  logic [RegAddrBits-1:0]     r_src2;
  logic [ParamBits-1:0]       r_param;
  logic [DataWidth-1:0]       r_res;
  logic                       r_illegal;
  logic                       r_is_cmp;

  logic                       w_is_cmp;
  logic                       w_legal;
  logic                       w_wb_we;

`ifdef ALU_CMP_EN
  assign w_is_cmp = (cmd_opcode == OpCmp);
`else
  assign w_is_cmp = 1'b0;
`endif

  assign w_legal = (cmd_opcode <= OpLastLegal) || w_is_cmp;

  // Held low while reset is asserted so nothing is accepted mid-reset.
  assign cmd_ready = (r_state == S_IDLE) && !rst;

  assign dbg_data = r_regs[dbg_addr];

  // Write-back is skipped for illegal opcodes and for CMP (flags-only).
  assign w_wb_we = (r_state == S_WB) && !r_illegal && !r_is_cmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opcode   <= '0;
      r_dst      <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_param    <= '0;
      r_res      <= '0;
      r_illegal  <= 1'b0;
      r_is_cmp   <= 1'b0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_param  <= '0;
      flags      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_opcode  <= cmd_opcode;
            r_dst     <= cmd_dst;
            r_src1    <= cmd_src1;
            r_src2    <= cmd_src2;
            r_param   <= cmd_param;
            r_illegal <= !w_legal;
            r_is_cmp  <= w_is_cmp;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          // Operands come from the pre-edge register file, so a load landing
          // on this same edge is not visible here.
          alu_op1    <= r_regs[r_src1];
          alu_op2    <= r_regs[r_src2];
          alu_opcode <= r_is_cmp ? OpSub : r_opcode;
          alu_param  <= r_param;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= alu_result;
          if (!r_illegal) begin
            flags <= alu_status;
          end
          // done/err are registered here so they are high throughout WB.
          done    <= 1'b1;
          err     <= r_illegal;
          r_state <= S_WB;
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: write-back wins over an external load to the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (w_wb_we && (r_dst == RegAddrBits'(i))) begin
          r_regs[i] <= r_res;
        end else if (ld_en && (ld_addr == RegAddrBits'(i))) begin
          r_regs[i] <= ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
// Bench for alu_exec_ctrl. A behavioural ALU_J model drives alu_result and
// alu_status. The expected register-file and flag state is kept as plain
// arrays and updated once per command at the transaction level.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_exec_ctrl;

`ifdef ALU_CMP_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_opcode;
  logic [2:0] cmd_dst, cmd_src1, cmd_src2;
  logic [7:0] cmd_param;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [4:0] alu_opcode;
  logic [7:0] alu_op1, alu_op2, alu_param;
  logic [7:0] alu_result;
  logic [5:0] alu_status;
  logic [5:0] flags;
  logic       done, err;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  always #10 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_dst(cmd_dst),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_param(cmd_param),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_param(alu_param), .alu_result(alu_result), .alu_status(alu_status),
    .flags(flags), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU_J behaviour: returns {status, result}; status = {sm, gt, eq, z, u, c}.
  function automatic logic [13:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] p);
    logic [8:0] s;
    logic [7:0] r;
    logic c, u;
    r = 8'h00; c = 1'b0; u = 1'b0; s = 9'h0;
    case (op)
      5'h00: r = 8'h00;
      5'h01: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      5'h02: begin r = a - b; u = (a < b); end
      5'h03: r = a & b;
      5'h04: r = a | b;
      5'h05: r = ~a;
      5'h06: r = a ^ b;
      5'h07: r = a << p;
      5'h08: r = a >> p;
      5'h09: r = p;
      default: return {6'h3F, 8'hA5};
    endcase
    return {a < b, a > b, a == b, r == 8'h00, u, c, r};
  endfunction

  always_comb {alu_status, alu_result} = alu_fn(alu_opcode, alu_op1, alu_op2, alu_param);

  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] m_regs [8];
  logic [5:0] m_flags;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_flags = 6'h00;
  endtask

  task automatic check_state();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("regfile", dbg_data, m_regs[i]);
    end
    chk("flags", flags, m_flags);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  // ph selects a concurrent ld_en pulse: 0 none, 1 READ, 2 EXEC, 3 WB cycle.
  task automatic run_cmd(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] p, input int ph,
                         input logic [2:0] la, input logic [7:0] ldv,
                         output int acc, output logic got_err);
    logic [7:0] a, b;
    logic [13:0] r;
    logic lg, cmp;
    logic [4:0] eop;
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("ready_wait", cmd_ready, 1);
    a = m_regs[s1]; b = m_regs[s2];
    cmp = CmpEn && (op == 5'h0A);
    lg  = (op <= 5'h09) || cmp;
    eop = cmp ? 5'h02 : op;
    r   = alu_fn(eop, a, b, p);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_dst = d;
    cmd_src1 = s1; cmd_src2 = s2; cmd_param = p;
    @(posedge clk);
    acc = cyc;
    #1;
    cmd_valid = 1'b0;
    cmd_opcode = 5'($urandom); cmd_dst = 3'($urandom);
    cmd_src1 = 3'($urandom); cmd_src2 = 3'($urandom); cmd_param = 8'($urandom);
    chk("ready_read", cmd_ready, 0);
    chk("done_read", done, 0);
    if (ph == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (ph == 1) m_regs[la] = ldv;
    chk("alu_opcode", alu_opcode, eop);
    chk("alu_op1", alu_op1, a);
    chk("alu_op2", alu_op2, b);
    chk("alu_param", alu_param, p);
    chk("done_exec", done, 0);
    if (ph == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (ph == 2) m_regs[la] = ldv;
    got_err = err;
    chk("done_wb", done, 1);
    chk("err_wb", err, !lg);
    if (lg) m_flags = r[13:8];
    chk("flags_wb", flags, m_flags);
    if (ph == 3) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (lg && !cmp) m_regs[d] = r[7:0];
    if (ph == 3 && !(lg && !cmp && la == d)) m_regs[la] = ldv;
    chk("done_after", done, 0);
    chk("err_after", err, 0);
    chk("ready_after", cmd_ready, 1);
    check_state();
  endtask

  typedef struct {
    logic [2:0] la; logic [7:0] da;
    logic [2:0] lb; logic [7:0] db;
    logic [4:0] op; logic [2:0] dst, s1, s2; logic [7:0] p;
    logic [7:0] exp_val; logic [5:0] exp_flags; logic exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2;
    logic e;
    logic [7:0] v;

    // Field order: la, da, lb, db, op, dst, s1, s2, p, exp_val, exp_flags, exp_err
    tbl[0] = '{3'd1, 8'd1,   3'd2, 8'd3,   5'h01, 3'd3, 3'd1, 3'd2, 8'd0, 8'd4,   6'h20, 1'b0};
    tbl[1] = '{3'd0, 8'd255, 3'd1, 8'd2,   5'h01, 3'd0, 3'd0, 3'd1, 8'd0, 8'd1,   6'h11, 1'b0};
    tbl[2] = '{3'd4, 8'd14,  3'd5, 8'd15,  5'h02, 3'd6, 3'd4, 3'd5, 8'd0, 8'd255, 6'h22, 1'b0};
    tbl[3] = '{3'd2, 8'h76,  3'd2, 8'h76,  5'h07, 3'd2, 3'd2, 3'd2, 8'd1, 8'hEC,  6'h08, 1'b0};
    tbl[4] = '{3'd7, 8'h11,  3'd7, 8'h11,  5'h1F, 3'd3, 3'd1, 3'd2, 8'd0, 8'd4,   6'h08, 1'b1};
    tbl[5] = '{3'd5, 8'hF0,  3'd7, 8'h3C,  5'h06, 3'd1, 3'd5, 3'd7, 8'd0, 8'hCC,  6'h10, 1'b0};
`ifdef ALU_CMP_EN
    tbl[6] = '{3'd3, 8'h7E,  3'd6, 8'h7E,  5'h0A, 3'd5, 3'd3, 3'd6, 8'd0, 8'hF0,  6'h0C, 1'b0};
`else
    tbl[6] = '{3'd3, 8'h7E,  3'd6, 8'h7E,  5'h0A, 3'd5, 3'd3, 3'd6, 8'd0, 8'hF0,  6'h10, 1'b1};
`endif
    tbl[7] = '{3'd0, 8'd1,   3'd0, 8'd1,   5'h09, 3'd4, 3'd0, 3'd0, 8'd0, 8'd0,   6'h0C, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_dst = '0; cmd_src1 = '0;
    cmd_src2 = '0; cmd_param = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    model_reset();
    #5;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_alu", {alu_opcode, alu_op1, alu_op2, alu_param}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check_state();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i].la, tbl[i].da);
      do_load(tbl[i].lb, tbl[i].db);
      run_cmd(tbl[i].op, tbl[i].dst, tbl[i].s1, tbl[i].s2, tbl[i].p, 0, 3'd0, 8'd0, acc1, e);
      read_reg(tbl[i].dst, v);
      chk("tbl_dst", v, tbl[i].exp_val);
      chk("tbl_flags", flags, tbl[i].exp_flags);
      chk("tbl_err", e, tbl[i].exp_err);
    end

    // Back-to-back: second accept exactly 4 cycles after the first
    do_load(3'd0, 8'd255);
    do_load(3'd1, 8'd2);
    run_cmd(5'h01, 3'd0, 3'd0, 3'd1, 8'd0, 0, 3'd0, 8'd0, acc1, e);
    run_cmd(5'h01, 3'd7, 3'd0, 3'd1, 8'd0, 0, 3'd0, 8'd0, acc2, e);
    chk("b2b_spacing", acc2 - acc1, 4);
    read_reg(3'd7, v);
    chk("b2b_result", v, 8'd3);

    // Load collides with write-back: write-back wins
    do_load(3'd2, 8'h76);
    run_cmd(5'h07, 3'd2, 3'd2, 3'd2, 8'd1, 3, 3'd2, 8'h55, acc1, e);
    read_reg(3'd2, v);
    chk("wb_beats_ld", v, 8'hEC);
    // Load to a different index in WB: both land
    run_cmd(5'h03, 3'd3, 3'd2, 3'd2, 8'd0, 3, 3'd4, 8'h5A, acc1, e);
    read_reg(3'd4, v);
    chk("wb_ld_other", v, 8'h5A);
    read_reg(3'd3, v);
    chk("wb_and", v, 8'hEC);
    // Load in READ to a source register: operand sees the old value
    do_load(3'd5, 8'h10);
    run_cmd(5'h01, 3'd6, 3'd5, 3'd5, 8'd0, 1, 3'd5, 8'h99, acc1, e);
    read_reg(3'd6, v);
    chk("read_pre_ld", v, 8'h20);

    // Randomized commands against the model
    for (int i = 0; i < 8; i++) do_load(3'(i), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(11, 31));
      else op = 5'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) do_load(3'($urandom), 8'($urandom));
      run_cmd(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom_range(0, 9)),
              int'($urandom_range(0, 3)), 3'($urandom), 8'($urandom), acc1, e);
    end

    // Reset during EXEC of an ADD
    do_load(3'd1, 8'h21);
    do_load(3'd2, 8'h13);
    cmd_valid = 1'b1; cmd_opcode = 5'h01; cmd_dst = 3'd3; cmd_src1 = 3'd1; cmd_src2 = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_rel_ready", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
    end
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
